// File: rtl/uart_apb_stream_master_if.sv
// rtl/uart_apb_stream_master_if.sv - APB bus and UART status flags between the stream master and the UART slave
interface uart_apb_stream_master_if;
   logic [4:0] M_PADDR;
   logic       M_PSEL;
   logic       M_PENABLE;
   logic       M_PWRITE;
   logic [7:0] M_PWDATA;
   logic [7:0] M_PRDATA;
   logic       M_PREADY;
   logic       M_PSLVERR;
   logic       UART_TXRDY;
   logic       UART_RXRDY;

   modport master (
      output M_PADDR, M_PSEL, M_PENABLE, M_PWRITE, M_PWDATA,
      input  M_PRDATA, M_PREADY, M_PSLVERR, UART_TXRDY, UART_RXRDY
   );

   modport slave (
      input  M_PADDR, M_PSEL, M_PENABLE, M_PWRITE, M_PWDATA,
      output M_PRDATA, M_PREADY, M_PSLVERR, UART_TXRDY, UART_RXRDY
   );
endinterface

// File: rtl/uart_apb_stream_master.sv
// rtl/uart_apb_stream_master.sv - APB master bridging byte streams to a CoreUARTapb-style UART
module uart_apb_stream_master #(
   parameter logic [12:0] BAUD_VALUE = 13'd1,
   parameter bit          BIT8       = 1'b1,
   parameter bit          PARITY_EN  = 1'b0,
   parameter bit          ODD_N_EVEN = 1'b0,
   parameter int unsigned HOLDOFF    = 2
) (
   input  logic                             PCLK,
   input  logic                             PRESET,
   uart_apb_stream_master_if.master         apb,
   input  logic [7:0]                       tx_data,
   input  logic                             tx_valid,
   output logic                             tx_ready,
   output logic [7:0]                       rx_data,
   output logic                             rx_valid,
   input  logic                             rx_ready,
   output logic                             cfg_done,
   output logic                             err_sticky,
   input  logic                             err_clr
);
   localparam logic [4:0] ADDR_TXDATA = 5'h00;
   localparam logic [4:0] ADDR_RXDATA = 5'h04;
   localparam logic [4:0] ADDR_CTRL1  = 5'h08;
   localparam logic [4:0] ADDR_CTRL2  = 5'h0C;
   localparam logic [3:0] HOLDOFF_CNT = 4'(HOLDOFF);
   localparam logic [7:0] CTRL1_VAL   = BAUD_VALUE[7:0];
   localparam logic [7:0] CTRL2_VAL   = {BAUD_VALUE[12:8], ODD_N_EVEN, PARITY_EN, BIT8};

   typedef enum logic [2:0] {S_CFG1, S_CFG2, S_IDLE, S_SETUP, S_ACCESS} state_t;
   // Remembers what the in-flight transfer is for, so ACCESS knows where to go on completion.
   typedef enum logic [1:0] {K_CFG1, K_CFG2, K_TX, K_RX} kind_t;

   state_t     state_q, state_d;
   kind_t      kind_q, kind_d;
   logic       psel_q, psel_d;
   logic       penable_q, penable_d;
   logic       pwrite_q, pwrite_d;
   logic [4:0] paddr_q, paddr_d;
   logic [7:0] pwdata_q, pwdata_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d;
   logic       cfg_done_q, cfg_done_d;
   logic       err_q, err_d;
   logic [3:0] holdoff_q, holdoff_d;

   // State register and all registered outputs; reset drops the bus immediately.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state_q    <= S_CFG1;
         kind_q     <= K_CFG1;
         psel_q     <= 1'b0;
         penable_q  <= 1'b0;
         pwrite_q   <= 1'b0;
         paddr_q    <= 5'd0;
         pwdata_q   <= 8'd0;
         rx_data_q  <= 8'd0;
         rx_valid_q <= 1'b0;
         cfg_done_q <= 1'b0;
         err_q      <= 1'b0;
         holdoff_q  <= 4'd0;
      end else begin
         state_q    <= state_d;
         kind_q     <= kind_d;
         psel_q     <= psel_d;
         penable_q  <= penable_d;
         pwrite_q   <= pwrite_d;
         paddr_q    <= paddr_d;
         pwdata_q   <= pwdata_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         cfg_done_q <= cfg_done_d;
         err_q      <= err_d;
         holdoff_q  <= holdoff_d;
      end
   end

   // Next-state: config writes, RX-first arbitration, APB SETUP/ACCESS sequencing.
   always_comb begin
      state_d    = state_q;
      kind_d     = kind_q;
      psel_d     = psel_q;
      penable_d  = penable_q;
      pwrite_d   = pwrite_q;
      paddr_d    = paddr_q;
      pwdata_d   = pwdata_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = rx_valid_q;
      cfg_done_d = cfg_done_q;
      err_d      = err_q;
      holdoff_d  = holdoff_q;
      tx_ready   = 1'b0;

      if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
      if (err_clr) err_d = 1'b0;

      case (state_q)
         S_CFG1: begin
            psel_d   = 1'b1;
            pwrite_d = 1'b1;
            paddr_d  = ADDR_CTRL1;
            pwdata_d = CTRL1_VAL;
            kind_d   = K_CFG1;
            state_d  = S_SETUP;
         end
         S_CFG2: begin
            psel_d   = 1'b1;
            pwrite_d = 1'b1;
            paddr_d  = ADDR_CTRL2;
            pwdata_d = CTRL2_VAL;
            kind_d   = K_CFG2;
            state_d  = S_SETUP;
         end
         S_IDLE: begin
            // Status flags lag our own accesses, so they are ignored until the holdoff drains.
            if (holdoff_q != 4'd0) begin
               holdoff_d = holdoff_q - 4'd1;
            end else if (apb.UART_RXRDY && !rx_valid_q) begin
               psel_d   = 1'b1;
               pwrite_d = 1'b0;
               paddr_d  = ADDR_RXDATA;
               kind_d   = K_RX;
               state_d  = S_SETUP;
            end else if (apb.UART_TXRDY && tx_valid) begin
               tx_ready = 1'b1;
               psel_d   = 1'b1;
               pwrite_d = 1'b1;
               paddr_d  = ADDR_TXDATA;
               pwdata_d = tx_data;
               kind_d   = K_TX;
               state_d  = S_SETUP;
            end
         end
         S_SETUP: begin
            penable_d = 1'b1;
            state_d   = S_ACCESS;
         end
         S_ACCESS: begin
            if (apb.M_PREADY) begin
               psel_d    = 1'b0;
               penable_d = 1'b0;
               if (apb.M_PSLVERR) err_d = 1'b1;
               case (kind_q)
                  K_CFG1: state_d = S_CFG2;
                  K_CFG2: begin
                     cfg_done_d = 1'b1;
                     state_d    = S_IDLE;
                  end
                  K_TX: begin
                     holdoff_d = HOLDOFF_CNT;
                     state_d   = S_IDLE;
                  end
                  K_RX: begin
                     rx_data_d  = apb.M_PRDATA;
                     rx_valid_d = 1'b1;
                     holdoff_d  = HOLDOFF_CNT;
                     state_d    = S_IDLE;
                  end
               endcase
            end
         end
         default: state_d = S_CFG1;
      endcase
   end

   assign apb.M_PSEL    = psel_q;
   assign apb.M_PENABLE = penable_q;
   assign apb.M_PWRITE  = pwrite_q;
   assign apb.M_PADDR   = paddr_q;
   assign apb.M_PWDATA  = pwdata_q;
   assign rx_data       = rx_data_q;
   assign rx_valid      = rx_valid_q;
   assign cfg_done      = cfg_done_q;
   assign err_sticky    = err_q;
endmodule

// File: tb/tb_uart_apb_stream_master.sv
// tb/tb_uart_apb_stream_master.sv - directed scoreboard bench for uart_apb_stream_master
module tb_uart_apb_stream_master;
   localparam logic [12:0] TB_BAUD = 13'h123;
   localparam logic [7:0]  CTRL1_EXP = TB_BAUD[7:0];
   localparam logic [7:0]  CTRL2_EXP = {TB_BAUD[12:8], 1'b0, 1'b0, 1'b1};

   typedef struct {
      logic       w;
      logic [4:0] a;
      logic [7:0] d;
   } xfer_t;

   logic       PCLK;
   logic       PRESET;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       cfg_done;
   logic       err_sticky;
   logic       err_clr;

   int checks = 0;
   int errors = 0;
   int xfer_cnt = 0;
   int setup_cnt = 0;
   int acc_len = 0;
   int last_len = 0;
   xfer_t exp_q[$];

   uart_apb_stream_master_if bus();

   uart_apb_stream_master #(
      .BAUD_VALUE(TB_BAUD), .BIT8(1'b1), .PARITY_EN(1'b0), .ODD_N_EVEN(1'b0), .HOLDOFF(2)
   ) dut (
      .PCLK(PCLK), .PRESET(PRESET), .apb(bus),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .cfg_done(cfg_done), .err_sticky(err_sticky), .err_clr(err_clr)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge PCLK);
      #1;
   endtask

   task automatic smp();
      @(negedge PCLK);
   endtask

   task automatic push(input logic w, input logic [4:0] a, input logic [7:0] d);
      xfer_t e;
      e.w = w;
      e.a = a;
      e.d = d;
      exp_q.push_back(e);
   endtask

   // Bus monitor: pops the scoreboard on every completing APB cycle.
   initial begin
      xfer_t e;
      forever begin
         @(negedge PCLK);
         if (PRESET) begin
            acc_len = 0;
         end else begin
            if (bus.M_PSEL && !bus.M_PENABLE) setup_cnt++;
            if (bus.M_PSEL && bus.M_PENABLE) acc_len++;
            if (bus.M_PSEL && bus.M_PENABLE && bus.M_PREADY) begin
               xfer_cnt++;
               last_len = acc_len;
               acc_len = 0;
               chk("sb_pending", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  chk("sb_write", bus.M_PWRITE, e.w);
                  chk("sb_addr", bus.M_PADDR, e.a);
                  if (e.w) chk("sb_wdata", bus.M_PWDATA, e.d);
               end
            end
         end
      end
   end

   initial begin
      int n;
      int base;
      logic tr [1:5];
      logic [1:0] pp [1:5];

      PRESET = 1'b1;
      tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0; err_clr = 1'b0;
      bus.M_PRDATA = 8'h00; bus.M_PREADY = 1'b1; bus.M_PSLVERR = 1'b0;
      bus.UART_TXRDY = 1'b0; bus.UART_RXRDY = 1'b0;
      repeat (3) cyc();
      smp();
      chk("rst_psel", bus.M_PSEL, 0);
      chk("rst_penable", bus.M_PENABLE, 0);
      chk("rst_pwrite", bus.M_PWRITE, 0);
      chk("rst_paddr", bus.M_PADDR, 0);
      chk("rst_pwdata", bus.M_PWDATA, 0);
      chk("rst_tx_ready", tx_ready, 0);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_rx_data", rx_data, 0);
      chk("rst_cfg_done", cfg_done, 0);
      chk("rst_err", err_sticky, 0);

      // Configuration after reset release.
      push(1'b1, 5'h08, CTRL1_EXP);
      push(1'b1, 5'h0C, CTRL2_EXP);
      setup_cnt = 0;
      xfer_cnt = 0;
      cyc();
      PRESET = 1'b0;
      n = 0;
      do begin smp(); n++; end while (!cfg_done && n < 30);
      chk("cfg_done", cfg_done, 1);
      chk("cfg_latency", n, 7);
      chk("cfg_xfers", xfer_cnt, 2);
      chk("cfg_setups", setup_cnt, 2);
      chk("cfg_access_len", last_len, 1);
      chk("cfg_sb_empty", exp_q.size(), 0);

      // TX with tx_valid held: two writes spaced by the holdoff.
      push(1'b1, 5'h00, 8'h5A);
      push(1'b1, 5'h00, 8'h5A);
      cyc();
      tx_data = 8'h5A; tx_valid = 1'b1; bus.UART_TXRDY = 1'b1;
      n = 0;
      do begin smp(); n++; end while (!tx_ready && n < 20);
      chk("tx_ready_first", tx_ready, 1);
      for (int j = 1; j <= 5; j++) begin
         cyc();
         smp();
         tr[j] = tx_ready;
         pp[j] = {bus.M_PSEL, bus.M_PENABLE};
      end
      chk("tx_setup_n1", pp[1], 2'b10);
      chk("tx_access_n2", pp[2], 2'b11);
      chk("tx_idle_n3", pp[3], 2'b00);
      chk("tx_ready_pulse", {tr[1], tr[2], tr[3], tr[4]}, 4'b0000);
      chk("tx_ready_after_holdoff", tr[5], 1);
      cyc();
      tx_valid = 1'b0; bus.UART_TXRDY = 1'b0;
      repeat (4) cyc();
      smp();
      chk("tx_sb_empty", exp_q.size(), 0);

      // RX: single-entry buffer blocks further reads until consumed.
      repeat (4) cyc();
      push(1'b0, 5'h04, 8'h00);
      base = xfer_cnt;
      bus.M_PRDATA = 8'hC3; bus.UART_RXRDY = 1'b1;
      n = 0;
      do begin smp(); n++; if (!rx_valid) cyc(); end while (!rx_valid && n < 20);
      chk("rx_valid", rx_valid, 1);
      chk("rx_data", rx_data, 8'hC3);
      chk("rx_one_read", xfer_cnt - base, 1);
      repeat (8) cyc();
      smp();
      chk("rx_no_reread", xfer_cnt - base, 1);
      chk("rx_valid_held", rx_valid, 1);
      push(1'b0, 5'h04, 8'h00);
      cyc();
      rx_ready = 1'b1; bus.M_PRDATA = 8'h3C;
      cyc();
      rx_ready = 1'b0;
      smp();
      chk("rx_valid_clear", rx_valid, 0);
      n = 0;
      do begin cyc(); smp(); n++; end while (!rx_valid && n < 20);
      bus.UART_RXRDY = 1'b0;
      chk("rx_second_data", rx_data, 8'h3C);
      chk("rx_second_read", xfer_cnt - base, 2);
      cyc();
      rx_ready = 1'b1;
      cyc();
      rx_ready = 1'b0;

      // RX and TX both pending: read wins, write follows after the holdoff.
      repeat (4) cyc();
      push(1'b0, 5'h04, 8'h00);
      push(1'b1, 5'h00, 8'hA5);
      base = xfer_cnt;
      bus.M_PRDATA = 8'h77; bus.UART_RXRDY = 1'b1; bus.UART_TXRDY = 1'b1;
      tx_valid = 1'b1; tx_data = 8'hA5;
      smp();
      chk("sim_tx_ready_low", tx_ready, 0);
      n = 0;
      do begin cyc(); smp(); n++; end while (!tx_ready && n < 20);
      chk("sim_tx_delay", n, 5);
      chk("sim_read_first", xfer_cnt - base, 1);
      chk("sim_rx_data", rx_data, 8'h77);
      cyc();
      tx_valid = 1'b0; bus.UART_RXRDY = 1'b0; bus.UART_TXRDY = 1'b0;
      repeat (3) cyc();
      smp();
      chk("sim_sb_empty", exp_q.size(), 0);
      cyc();
      rx_ready = 1'b1;
      cyc();
      rx_ready = 1'b0;

      // Wait states with a slave error on the completing cycle.
      repeat (4) cyc();
      push(1'b1, 5'h00, 8'h11);
      bus.M_PREADY = 1'b0; tx_data = 8'h11; tx_valid = 1'b1; bus.UART_TXRDY = 1'b1;
      n = 0;
      do begin smp(); n++; if (!tx_ready) cyc(); end while (!tx_ready && n < 20);
      chk("ws_tx_ready", tx_ready, 1);
      cyc();
      tx_valid = 1'b0; bus.UART_TXRDY = 1'b0;
      repeat (4) cyc();
      bus.M_PREADY = 1'b1; bus.M_PSLVERR = 1'b1;
      cyc();
      bus.M_PSLVERR = 1'b0;
      smp();
      chk("ws_access_len", last_len, 4);
      chk("ws_err_sticky", err_sticky, 1);
      chk("ws_psel_drop", bus.M_PSEL, 0);
      chk("ws_sb_empty", exp_q.size(), 0);
      cyc();
      err_clr = 1'b1;
      cyc();
      err_clr = 1'b0;
      smp();
      chk("ws_err_cleared", err_sticky, 0);

      // Reset asserted during ACCESS of a TX write.
      repeat (4) cyc();
      bus.M_PREADY = 1'b0; tx_data = 8'h99; tx_valid = 1'b1; bus.UART_TXRDY = 1'b1;
      n = 0;
      do begin smp(); n++; if (!tx_ready) cyc(); end while (!tx_ready && n < 20);
      chk("mr_tx_ready", tx_ready, 1);
      cyc();
      tx_valid = 1'b0; bus.UART_TXRDY = 1'b0;
      cyc();
      smp();
      chk("mr_in_access", {bus.M_PSEL, bus.M_PENABLE}, 2'b11);
      #1 PRESET = 1'b1;
      #1;
      chk("mr_psel", bus.M_PSEL, 0);
      chk("mr_penable", bus.M_PENABLE, 0);
      chk("mr_pwdata", bus.M_PWDATA, 0);
      chk("mr_paddr", bus.M_PADDR, 0);
      chk("mr_cfg_done", cfg_done, 0);
      chk("mr_rx_valid", rx_valid, 0);
      bus.M_PREADY = 1'b1;
      push(1'b1, 5'h08, CTRL1_EXP);
      push(1'b1, 5'h0C, CTRL2_EXP);
      cyc();
      PRESET = 1'b0;
      n = 0;
      do begin smp(); n++; end while (!cfg_done && n < 30);
      chk("mr_cfg_done_again", cfg_done, 1);
      chk("mr_cfg_latency", n, 7);
      chk("mr_sb_empty", exp_q.size(), 0);

      repeat (2) cyc();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
